multicycle_processor: RTL

MULTICYCLE_PROCESSOR -- requirements
Module: multicycle_processor

---
 rtl/multicycle_processor.sv | 134 +++++++++++++
 1 files changed

// File: rtl/multicycle_processor.sv
// Multicycle processor: eight-register file, shared bus, A/G ALU staging and a four-step
// T0..T3 sequencer executing mv, mvi, add, sub, and, mvnz and NOP instructions.
module multicycle_processor #(
    parameter int N = 16
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         Run,
    input  logic [N-1:0] DIN,
    output logic         Done,
    output logic         Busy,
    output logic [N-1:0] BusWires,
    output logic [N-1:0] R0,
    output logic [N-1:0] R1,
    output logic [8:0]   IR,
    output logic         Z,
    output logic [1:0]   Tstep
);

    typedef enum logic [1:0] {T0 = 2'b00, T1 = 2'b01, T2 = 2'b10, T3 = 2'b11} step_e;

    step_e        state_q, state_d;
    logic [N-1:0] r_q [8];
    logic [N-1:0] a_q, g_q, g_d;
    logic [8:0]   ir_q;
    logic         z_q, z_d;

    logic [7:0]   r_in, r_out, x_oh, y_oh;
    logic         din_out, g_out, ir_in, a_in, g_in, done_c;
    logic [2:0]   opcode, x, y;
    logic         is_alu;

    assign opcode = ir_q[8:6];
    assign x      = ir_q[5:3];
    assign y      = ir_q[2:0];
    assign x_oh   = 8'b1 << x;
    assign y_oh   = 8'b1 << y;
    assign is_alu = opcode inside {3'b010, 3'b011, 3'b100};

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state_q <= T0;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            T0: if (Run) state_d = T1;
            T1: state_d = is_alu ? T2 : T0;
            T2: state_d = T3;
            T3: state_d = T0;
            default: state_d = T0;
        endcase
    end

    always_comb begin
        r_in    = '0;
        r_out   = '0;
        din_out = 1'b0;
        g_out   = 1'b0;
        ir_in   = 1'b0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            T0: ir_in = Run;
            T1: begin
                case (opcode)
                    3'b000: begin r_out = y_oh; r_in = x_oh; done_c = 1'b1; end
                    3'b001: begin din_out = 1'b1; r_in = x_oh; done_c = 1'b1; end
                    3'b010, 3'b011, 3'b100: begin r_out = x_oh; a_in = 1'b1; end
                    3'b101: begin
                        r_out  = y_oh;
                        r_in   = z_q ? 8'b0 : x_oh;
                        done_c = 1'b1;
                    end
                    default: done_c = 1'b1;
                endcase
            end
            T2: begin r_out = y_oh; g_in = 1'b1; end
            T3: begin g_out = 1'b1; r_in = x_oh; done_c = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        BusWires = '0;
        if (|r_out) begin
            for (int unsigned i = 0; i < 8; i++)
                if (r_out[i]) BusWires = r_q[i[2:0]];
        end else if (din_out) begin
            BusWires = DIN;
        end else if (g_out) begin
            BusWires = g_q;
        end
    end

    always_comb begin
        case (opcode)
            3'b010:  g_d = a_q + BusWires;
            3'b011:  g_d = a_q - BusWires;
            default: g_d = a_q & BusWires;
        endcase
        z_d = (g_d == '0);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int unsigned i = 0; i < 8; i++) r_q[i[2:0]] <= '0;
            a_q  <= '0;
            g_q  <= '0;
            ir_q <= '0;
            z_q  <= 1'b0;
        end else begin
            if (ir_in) ir_q <= DIN[8:0];
            if (a_in)  a_q  <= BusWires;
            if (g_in) begin
                g_q <= g_d;
                z_q <= z_d;
            end
            for (int unsigned i = 0; i < 8; i++)
                if (r_in[i]) r_q[i[2:0]] <= BusWires;
        end
    end

    assign R0    = r_q[0];
    assign R1    = r_q[1];
    assign IR    = ir_q;
    assign Z     = z_q;
    assign Tstep = state_q;
    assign Done  = done_c;
    assign Busy  = (state_q != T0);

endmodule
